// File: rtl/bit_stack_ctrl.sv
// Valid/ready front end for an N-bit shift-register bit stack.
// Ports: clk, reset_n (sync, active-low); req_valid/req_ready/req_op/req_data request handshake;
// rsp_valid/rsp_ready/rsp_data/rsp_err response handshake;
// stk_push/stk_pop/stk_wr_en/stk_wr_data strobes to the stack; stk_in (bit 0 = top) from the stack;
// depth/full/empty occupancy; err_mismatch sticky shadow check (built only with BIT_STACK_SHADOW_EN).
module bit_stack_ctrl #(
  parameter  int N       = 5,
  localparam int DEPTH_W = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_op,
  input  logic               req_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_data,
  output logic               rsp_err,
  output logic               stk_push,
  output logic               stk_pop,
  output logic               stk_wr_en,
  output logic               stk_wr_data,
  input  logic [N-1:0]       stk_in,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty,
  output logic               err_mismatch
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic acc;
  logic bad;
  logic ok_push;
  logic ok_pop;

  assign req_ready = reset_n && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign full      = (depth == DEPTH_W'(N));
  assign empty     = (depth == '0);

  assign acc     = req_valid && req_ready;
  // Overflow/underflow requests never reach the stack.
  assign bad     = req_op ? empty : full;
  assign ok_push = !req_op && !bad;
  assign ok_pop  = req_op && !bad;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (acc) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_wr_en   <= 1'b0;
      stk_wr_data <= 1'b0;
      rsp_data    <= 1'b0;
      rsp_err     <= 1'b0;
      depth       <= '0;
    end else begin
      // Strobes are single-cycle pulses covering EXEC only.
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_wr_en   <= 1'b0;
      stk_wr_data <= 1'b0;
      if (acc) begin
        stk_push    <= ok_push;
        stk_wr_en   <= ok_push;
        stk_wr_data <= ok_push && req_data;
        stk_pop     <= ok_pop;
        rsp_data    <= ok_pop && stk_in[0];
        rsp_err     <= bad;
      end
      if (state_q == EXEC) begin
        if (stk_push)     depth <= depth + DEPTH_W'(1);
        else if (stk_pop) depth <= depth - DEPTH_W'(1);
      end
      if (state_q == RESP && rsp_ready) begin
        rsp_data <= 1'b0;
        rsp_err  <= 1'b0;
      end
    end
  end

`ifdef BIT_STACK_SHADOW_EN
  logic [N-1:0] shadow;
  logic         mism;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow <= '0;
      mism   <= 1'b0;
    end else begin
      if (state_q == EXEC) begin
        if (stk_push)     shadow <= {shadow[N-2:0], stk_wr_data};
        else if (stk_pop) shadow <= {1'b0, shadow[N-1:1]};
      end
      if (state_q == IDLE && stk_in != shadow) mism <= 1'b1;
    end
  end

  assign err_mismatch = mism;
`else
  logic unused_stk;
  assign unused_stk   = ^stk_in[N-1:1];
  assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_bit_stack_ctrl.sv
// Bench for bit_stack_ctrl: table of request vectors with a response scoreboard,
// plus hand sequences for response back-pressure, mid-operation reset and the shadow check.
module tb_bit_stack_ctrl;
  localparam int N = 5;
  localparam int DW = $clog2(N + 1);

  logic clk = 0;
  logic reset_n = 0;
  logic req_valid = 0, req_ready, req_op = 0, req_data = 0;
  logic rsp_valid, rsp_ready = 1, rsp_data, rsp_err;
  logic stk_push, stk_pop, stk_wr_en, stk_wr_data;
  logic [N-1:0] stk_in, stk, flip = '0;
  logic [DW-1:0] depth;
  logic full, empty, err_mismatch;

  int vectors = 0, miscompares = 0;
  int push_cnt = 0, pop_cnt = 0, viol = 0;
  logic [1:0] sb[$];

  always #5 clk = ~clk;

  bit_stack_ctrl #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wr_en(stk_wr_en), .stk_wr_data(stk_wr_data),
    .stk_in(stk_in), .depth(depth),
    .full(full), .empty(empty), .err_mismatch(err_mismatch)
  );

  // Behavioural shift-register stack, reset together with the controller.
  always @(posedge clk) begin
    if (!reset_n) stk <= '0;
    else if (stk_push && stk_wr_en) stk <= {stk[N-2:0], stk_wr_data};
    else if (stk_pop) stk <= {1'b0, stk[N-1:1]};
  end
  assign stk_in = stk ^ flip;

  always @(posedge clk) begin
    if (stk_push) push_cnt++;
    if (stk_pop) pop_cnt++;
    if ((stk_push && stk_pop) || (stk_wr_en && !stk_push)) viol++;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic xact(input logic op, input logic d, input logic ed,
                      input logic ee, input int edep);
    int p0, q0;
    logic [1:0] e;
    wait_ready();
    if (!req_ready) begin chk("req_ready_timeout", 0, 1); return; end
    req_valid = 1; req_op = op; req_data = d;
    sb.push_back({ed, ee});
    p0 = push_cnt; q0 = pop_cnt;
    @(negedge clk);
    req_valid = 0;
    wait_rsp();
    e = sb.pop_front();
    if (!rsp_valid) begin chk("rsp_valid_timeout", 0, 1); return; end
    chk("rsp_data", int'(rsp_data), int'(e[1]));
    chk("rsp_err", int'(rsp_err), int'(e[0]));
    @(negedge clk);
    chk("depth", int'(depth), edep);
    chk("push_pulses", push_cnt - p0, int'(!ee && !op));
    chk("pop_pulses", pop_cnt - q0, int'(!ee && op));
  endtask

  typedef struct {
    logic op; logic d; logic ed; logic ee; int dep;
  } vec_t;
  vec_t tbl[15];

  initial begin
    logic held;
    int p0, q0;
    tbl[0]  = '{1, 0, 0, 1, 0};
    tbl[1]  = '{0, 1, 0, 0, 1};
    tbl[2]  = '{0, 0, 0, 0, 2};
    tbl[3]  = '{0, 1, 0, 0, 3};
    tbl[4]  = '{1, 0, 1, 0, 2};
    tbl[5]  = '{1, 0, 0, 0, 1};
    tbl[6]  = '{1, 0, 1, 0, 0};
    tbl[7]  = '{1, 0, 0, 1, 0};
    tbl[8]  = '{0, 1, 0, 0, 1};
    tbl[9]  = '{0, 1, 0, 0, 2};
    tbl[10] = '{0, 1, 0, 0, 3};
    tbl[11] = '{0, 1, 0, 0, 4};
    tbl[12] = '{0, 1, 0, 0, 5};
    tbl[13] = '{0, 0, 0, 1, 5};
    tbl[14] = '{1, 0, 1, 0, 4};

    repeat (2) @(negedge clk);
    chk("req_ready_in_reset", int'(req_ready), 0);
    reset_n = 1;
    repeat (3) @(negedge clk);
    chk("rst_depth", int'(depth), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_strobes", int'({stk_push, stk_pop, stk_wr_en, stk_wr_data}), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_err_mismatch", int'(err_mismatch), 0);

    for (int i = 0; i < 15; i++) begin
      xact(tbl[i].op, tbl[i].d, tbl[i].ed, tbl[i].ee, tbl[i].dep);
      if (i == 3) chk("stk_after_101", int'(stk_in), 5);
      if (i == 13) begin
        chk("stk_full_ones", int'(stk_in), 31);
        chk("full_flag", int'(full), 1);
      end
    end

    // Response back-pressure: push 0 at depth 4, hold rsp_ready low.
    rsp_ready = 0;
    wait_ready();
    req_valid = 1; req_op = 0; req_data = 0;
    sb.push_back(2'b00);
    @(negedge clk);
    req_valid = 0;
    wait_rsp();
    p0 = push_cnt; q0 = pop_cnt;
    held = rsp_data;
    for (int k = 0; k < 4; k++) begin
      chk("hold_rsp_valid", int'(rsp_valid), 1);
      chk("hold_rsp_data", int'(rsp_data), int'(held));
      chk("hold_req_ready", int'(req_ready), 0);
      @(negedge clk);
    end
    chk("hold_no_strobes", (push_cnt - p0) + (pop_cnt - q0), 0);
    begin
      logic [1:0] e;
      e = sb.pop_front();
      chk("hold_data", int'(rsp_data), int'(e[1]));
      chk("hold_err", int'(rsp_err), int'(e[0]));
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("hold_release_idle", int'(req_ready), 1);
    chk("hold_release_valid", int'(rsp_valid), 0);
    chk("hold_depth", int'(depth), 5);

    // Top is the 0 just pushed.
    xact(1, 0, 0, 0, 4);

    // Reset while a push is in EXEC.
    wait_ready();
    req_valid = 1; req_op = 0; req_data = 1;
    @(negedge clk);
    req_valid = 0;
    chk("exec_push_strobe", int'(stk_push), 1);
    reset_n = 0;
    @(negedge clk);
    chk("abort_strobes", int'({stk_push, stk_pop, stk_wr_en}), 0);
    chk("abort_depth", int'(depth), 0);
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    chk("abort_req_ready", int'(req_ready), 0);
    reset_n = 1;
    repeat (2) @(negedge clk);
    chk("abort_stack_clear", int'(stk_in), 0);
    chk("abort_idle", int'(req_ready), 1);
    xact(0, 1, 0, 0, 1);

`ifdef BIT_STACK_SHADOW_EN
    chk("shadow_clean", int'(err_mismatch), 0);
    flip = 5'b00100;
    repeat (2) @(negedge clk);
    flip = '0;
    repeat (3) @(negedge clk);
    chk("shadow_sticky", int'(err_mismatch), 1);
`else
    flip = 5'b00100;
    repeat (2) @(negedge clk);
    flip = '0;
    chk("no_shadow_tied", int'(err_mismatch), 0);
`endif

    chk("strobe_rules", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
